// File: rtl/ysyx_22050368_ifu.sv
// Instruction fetch unit: holds the PC, issues one word fetch at a time on a
// valid/ready memory interface, buffers returned words in a small queue and
// hands {instruction, PC} to decode. Redirects flush the queue and any fetch
// still in flight.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   redirect_i      flush and restart fetch at redirect_pc_i
//   redirect_pc_i   new fetch PC (low two bits ignored)
//   req_valid_o     fetch request valid
//   req_ready_i     memory accepts request
//   req_addr_o      word-aligned fetch address
//   resp_valid_i    fetch data returned (single-cycle pulse)
//   resp_data_i     fetched instruction word
//   inst_valid_o    queue head valid toward decode
//   inst_ready_i    decode consumes head
//   inst_o          head instruction
//   inst_addr_o     head PC
module ysyx_22050368_ifu #(
    parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [63:0] req_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [63:0]      pc, pc_nxt;
    logic [63:0]      inflight_pc, inflight_pc_nxt;
    logic             drop, drop_nxt;
    logic [PTR_W-1:0] head, head_nxt;
    logic [PTR_W-1:0] tail, tail_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [31:0]      q_inst     [QUEUE_DEPTH];
    logic [31:0]      q_inst_nxt [QUEUE_DEPTH];
    logic [63:0]      q_addr     [QUEUE_DEPTH];
    logic [63:0]      q_addr_nxt [QUEUE_DEPTH];

    logic             req_valid_nxt;
    logic             inst_valid_nxt;
    logic [31:0]      inst_nxt;
    logic [63:0]      inst_addr_nxt;

    logic             fire;
    logic             resp;
    logic             push;
    logic             pop;

    // The PC register drives the request address directly; it only moves on
    // a handshake or a redirect, so the address is stable while stalled.
    assign req_addr_o = pc;

    // Next-state, queue update and registered-output computation.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inflight_pc_nxt = inflight_pc;
        drop_nxt        = drop;
        head_nxt        = head;
        tail_nxt        = tail;
        count_nxt       = count;
        q_inst_nxt      = q_inst;
        q_addr_nxt      = q_addr;

        fire = (state == ST_REQ) && req_valid_o && req_ready_i;
        resp = (state == ST_WAIT) && resp_valid_i;
        push = resp && !drop;
        pop  = inst_valid_o && inst_ready_i;

        if (redirect_i) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
            pc_nxt    = {redirect_pc_i[63:2], 2'b00};
            if (fire) begin
                // The request just accepted belongs to the old path.
                state_nxt       = ST_WAIT;
                drop_nxt        = 1'b1;
                inflight_pc_nxt = pc;
            end else if ((state == ST_WAIT) && !resp_valid_i) begin
                // Old fetch still outstanding: discard it when it returns.
                state_nxt = ST_WAIT;
                drop_nxt  = 1'b1;
            end else begin
                // Nothing outstanding (or it returns right now and is thrown away).
                state_nxt = ST_REQ;
                drop_nxt  = 1'b0;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (fire) begin
                        inflight_pc_nxt = pc;
                        pc_nxt          = pc + 64'd4;
                        state_nxt       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp) begin
                        drop_nxt  = 1'b0;
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_REQ;
            endcase

            if (push) begin
                q_inst_nxt[tail] = resp_data_i;
                q_addr_nxt[tail] = inflight_pc;
                tail_nxt         = tail + PTR_W'(1);
            end
            if (pop) begin
                head_nxt = head + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        end

        // Requests only go out when a slot is free, so pushes never overflow.
        req_valid_nxt  = (state_nxt == ST_REQ) && (count_nxt < CNT_W'(QUEUE_DEPTH));
        inst_valid_nxt = (count_nxt != '0);
        inst_nxt       = inst_valid_nxt ? q_inst_nxt[head_nxt] : 32'h0;
        inst_addr_nxt  = inst_valid_nxt ? q_addr_nxt[head_nxt] : 64'h0;
    end

    // State, queue and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            inflight_pc  <= 64'h0;
            drop         <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            req_valid_o  <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'h0;
            inst_addr_o  <= 64'h0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_inst[i] <= 32'h0;
                q_addr[i] <= 64'h0;
            end
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            inflight_pc  <= inflight_pc_nxt;
            drop         <= drop_nxt;
            head         <= head_nxt;
            tail         <= tail_nxt;
            count        <= count_nxt;
            req_valid_o  <= req_valid_nxt;
            inst_valid_o <= inst_valid_nxt;
            inst_o       <= inst_nxt;
            inst_addr_o  <= inst_addr_nxt;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_inst[i] <= q_inst_nxt[i];
                q_addr[i] <= q_addr_nxt[i];
            end
        end
    end

endmodule
